// File: rtl/list_builder.sv
// list_builder: builds a null-terminated singly linked list in memory from a valid/ready value stream
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      one-cycle pulse, begins a new empty list (honoured in IDLE, READY, DONE)
//   in_valid   in_data/in_last are valid
//   in_data    node value to store
//   in_last    final value of the list
//   in_ready   a value can be accepted this cycle
//   mem_we     memory write enable
//   mem_addr   memory write address (holds while mem_we is low)
//   mem_wdata  memory write data (holds while mem_we is low)
//   busy       high outside IDLE and DONE
//   done       one-cycle pulse on list completion
//   full       node space exhausted
//   list_len   number of nodes linked so far
//
// Memory layout: word 0 unused, word 1 is the head pointer, a node at even
// address A keeps its value at A and its next pointer at A+1, pointer 0 ends
// the list.
//
// Build option: define LIST_PREPEND_EN to insert each node at the head of the
// list (reverse arrival order) instead of appending it at the tail.
module list_builder #(
    parameter int BITWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                mem_we,
    output logic [BITWIDTH-1:0] mem_addr,
    output logic [BITWIDTH-1:0] mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                full,
    output logic [BITWIDTH-1:0] list_len
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INIT   = 3'd1;
    localparam logic [2:0] READY  = 3'd2;
    localparam logic [2:0] W_VAL  = 3'd3;
    localparam logic [2:0] W_NXT  = 3'd4;
    localparam logic [2:0] W_LINK = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic [BITWIDTH-1:0] ZERO       = '0;
    localparam logic [BITWIDTH-1:0] ONE        = BITWIDTH'(1);
    localparam logic [BITWIDTH-1:0] HEAD_ADDR  = BITWIDTH'(1);
    localparam logic [BITWIDTH-1:0] FIRST_NODE = BITWIDTH'(2);

    logic [2:0]          state_q, state_d;
    logic [BITWIDTH-1:0] free_ptr_q, free_ptr_d;
    logic [BITWIDTH-1:0] head_q, head_d;
    logic [BITWIDTH-1:0] val_q, val_d;
    logic [BITWIDTH-1:0] a_q, a_d;
    logic [BITWIDTH-1:0] len_q, len_d;
    logic [BITWIDTH-1:0] addr_q, addr_d;
    logic [BITWIDTH-1:0] wdata_q, wdata_d;
    logic                last_q, last_d;
    logic                full_q, full_d;
    logic                done_q, done_d;
`ifndef LIST_PREPEND_EN
    logic [BITWIDTH-1:0] tail_q, tail_d;
`endif

    logic                we;
    logic                restart;
    logic                hs;
    logic [BITWIDTH-1:0] a_next;

    always_comb begin
        state_d    = state_q;
        free_ptr_d = free_ptr_q;
        head_d     = head_q;
        val_d      = val_q;
        a_d        = a_q;
        len_d      = len_q;
        last_d     = last_q;
        full_d     = full_q;
`ifndef LIST_PREPEND_EN
        tail_d     = tail_q;
`endif
        we         = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        a_next     = a_q + FIRST_NODE;
        restart    = start && (state_q == IDLE || state_q == READY || state_q == DONE);
        hs         = (state_q == READY) && in_valid && !full_q;
        // start outranks a simultaneous handshake in READY
        if (restart) begin
            state_d    = INIT;
            free_ptr_d = FIRST_NODE;
            head_d     = ZERO;
            len_d      = ZERO;
            full_d     = 1'b0;
`ifndef LIST_PREPEND_EN
            tail_d     = ZERO;
`endif
        end else begin
            case (state_q)
                INIT: begin
                    we      = 1'b1;
                    addr_d  = HEAD_ADDR;
                    wdata_d = ZERO;
                    state_d = READY;
                end
                READY: begin
                    if (hs) begin
                        val_d   = in_data;
                        a_d     = free_ptr_q;
                        last_d  = in_last;
                        state_d = W_VAL;
                    end else if (full_q && in_valid && in_last) begin
                        // no room for the final beat: drop it and close the list
                        state_d = DONE;
                    end
                end
                W_VAL: begin
                    we      = 1'b1;
                    addr_d  = a_q;
                    wdata_d = val_q;
                    state_d = W_NXT;
                end
                W_NXT: begin
                    we      = 1'b1;
                    addr_d  = a_q + ONE;
`ifdef LIST_PREPEND_EN
                    wdata_d = head_q;
`else
                    wdata_d = ZERO;
`endif
                    state_d = W_LINK;
                end
                W_LINK: begin
                    we         = 1'b1;
                    wdata_d    = a_q;
`ifdef LIST_PREPEND_EN
                    addr_d     = HEAD_ADDR;
                    head_d     = a_q;
`else
                    // the first node hangs off the head word, later ones off the tail's next field
                    addr_d     = (head_q == ZERO) ? HEAD_ADDR : tail_q + ONE;
                    head_d     = (head_q == ZERO) ? a_q : head_q;
                    tail_d     = a_q;
`endif
                    len_d      = len_q + ONE;
                    free_ptr_d = a_next;
                    full_d     = (a_next == ZERO);
                    state_d    = last_q ? DONE : READY;
                end
                default: ;
            endcase
        end
        done_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            free_ptr_q <= FIRST_NODE;
            head_q     <= ZERO;
            val_q      <= ZERO;
            a_q        <= ZERO;
            len_q      <= ZERO;
            addr_q     <= ZERO;
            wdata_q    <= ZERO;
            last_q     <= 1'b0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
`ifndef LIST_PREPEND_EN
            tail_q     <= ZERO;
`endif
        end else begin
            state_q    <= state_d;
            free_ptr_q <= free_ptr_d;
            head_q     <= head_d;
            val_q      <= val_d;
            a_q        <= a_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
            full_q     <= full_d;
            done_q     <= done_d;
`ifndef LIST_PREPEND_EN
            tail_q     <= tail_d;
`endif
        end
    end

    // address/data come straight from the next-value mux so the write lands in
    // the same cycle as mem_we, and the registered copy holds them afterwards
    assign mem_we    = we;
    assign mem_addr  = addr_d;
    assign mem_wdata = wdata_d;
    assign in_ready  = (state_q == READY) && !full_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = done_q;
    assign full      = full_q;
    assign list_len  = len_q;
endmodule

// File: tb/tb_list_builder.sv
// tb_list_builder: self-checking bench for list_builder with a memory model, list walker and reference model
module tb_list_builder;
`ifdef LIST_PREPEND_EN
    localparam bit PREP = 1'b1;
`else
    localparam bit PREP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_ready, mem_we, busy, done, full;
    logic [7:0] mem_addr, mem_wdata, list_len;

    list_builder #(.BITWIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .full(full), .list_len(list_len)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    bit [7:0] mem [256];
    logic [15:0] wlog[$];

    always @(negedge clk) begin
        if (mem_we) begin
            wlog.push_back({mem_addr, mem_wdata});
            mem[mem_addr] <= mem_wdata;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct packed {
        logic [7:0]       din;
        logic             last;
        logic [2:0][7:0]  wa;
        logic [2:0][7:0]  wd;
        logic [7:0]       len;
    } vec_t;

    vec_t tbl[3];

    function automatic vec_t mk(input logic [7:0] din, input logic last,
                                input logic [7:0] a0, input logic [7:0] d0,
                                input logic [7:0] a1, input logic [7:0] d1,
                                input logic [7:0] a2, input logic [7:0] d2,
                                input logic [7:0] len);
        vec_t v;
        v.din = din; v.last = last; v.len = len;
        v.wa[0] = a0; v.wa[1] = a1; v.wa[2] = a2;
        v.wd[0] = d0; v.wd[1] = d1; v.wd[2] = d2;
        return v;
    endfunction

    function automatic logic [15:0] logat(input int i);
        return (i < wlog.size()) ? wlog[i] : 16'hxxxx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input logic l, output bit ok);
        in_valid = 1'b1; in_data = v; in_last = l; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_zero_outs(input string tag);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, " in_ready"}, 32'(in_ready), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " full"}, 32'(full), 0);
        chk({tag, " list_len"}, 32'(list_len), 0);
    endtask

    // Walks the list in the memory model the way the reader side would
    task automatic walk(output logic [7:0] sum, output logic [7:0] seq[$]);
        logic [7:0] p;
        sum = '0;
        seq.delete();
        p = mem[1];
        for (int k = 0; k < 200 && p != 0; k++) begin
            sum += mem[p];
            seq.push_back(mem[p]);
            p = mem[8'(p + 1)];
        end
    endtask

    // Reference: node i lives at 2+2i; expected writes and expected walk order
    task automatic model(input logic [7:0] vals[$], output logic [15:0] exp[$], output logic [7:0] ord[$]);
        logic [7:0] a;
        exp.delete();
        ord.delete();
        exp.push_back(16'h0100);
        foreach (vals[i]) begin
            a = 8'(2 + 2 * i);
            exp.push_back({a, vals[i]});
            exp.push_back({8'(a + 1), (PREP && i > 0) ? 8'(a - 2) : 8'h00});
            exp.push_back({(PREP || i == 0) ? 8'h01 : 8'(a - 1), a});
            if (PREP) ord.push_front(vals[i]);
            else ord.push_back(vals[i]);
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] vals[$]);
        logic [15:0] exp[$];
        logic [7:0] ord[$];
        logic [7:0] seq[$];
        logic [7:0] sum, esum;
        model(vals, exp, ord);
        chk({tag, " write count"}, wlog.size(), exp.size());
        foreach (exp[i]) chk($sformatf("%s write %0d", tag, i), 32'(logat(i)), 32'(exp[i]));
        walk(sum, seq);
        esum = '0;
        foreach (vals[i]) esum += vals[i];
        chk({tag, " walk sum"}, 32'(sum), 32'(esum));
        chk({tag, " walk len"}, seq.size(), ord.size());
        foreach (ord[i]) chk($sformatf("%s walk node %0d", tag, i), 32'((i < seq.size()) ? seq[i] : 8'hxx), 32'(ord[i]));
    endtask

    task automatic run_list(input logic [7:0] vals[$], input int gmax, input string tag);
        bit ok;
        int d0, nok;
        wlog.delete();
        pulse_start();
        chk({tag, " len after start"}, 32'(list_len), 0);
        chk({tag, " full after start"}, 32'(full), 0);
        d0 = done_cnt;
        nok = 0;
        foreach (vals[i]) begin
            cyc($urandom_range(gmax, 0));
            send(vals[i], i == vals.size() - 1, ok);
            nok += int'(ok);
        end
        chk({tag, " handshakes"}, nok, vals.size());
        cyc(5);
        chk({tag, " done pulses"}, done_cnt - d0, 1);
        chk({tag, " list_len"}, 32'(list_len), vals.size());
        chk({tag, " busy at end"}, 32'(busy), 0);
        check_result(tag, vals);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vals[$];
        logic [7:0] seq[$];
        logic [7:0] sum;
        bit ok;
        int n0, nok, rdy_seen, d0;

        tbl[0] = mk(8'd5, 1'b0, 8'd2, 8'd5, 8'd3, 8'd0, 8'd1, 8'd2, 8'd1);
        tbl[1] = mk(8'd7, 1'b0, 8'd4, 8'd7, 8'd5, PREP ? 8'd2 : 8'd0, PREP ? 8'd1 : 8'd3, 8'd4, 8'd2);
        tbl[2] = mk(8'd9, 1'b1, 8'd6, 8'd9, 8'd7, PREP ? 8'd4 : 8'd0, PREP ? 8'd1 : 8'd5, 8'd6, 8'd3);

        #23;
        check_zero_outs("reset");
        rst = 1'b0;
        cyc(3);
        chk("idle no writes", wlog.size(), 0);

        // table: 5, 7, 9
        wlog.delete();
        pulse_start();
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            n0 = 1 + 3 * i;
            send(tbl[i].din, tbl[i].last, ok);
            chk($sformatf("tbl%0d handshake", i), 32'(ok), 1);
            cyc(3);
            for (int k = 0; k < 3; k++)
                chk($sformatf("tbl%0d write %0d", i, k), 32'(logat(n0 + k)), 32'({tbl[i].wa[k], tbl[i].wd[k]}));
            chk($sformatf("tbl%0d list_len", i), 32'(list_len), 32'(tbl[i].len));
        end
        chk("tbl init write", 32'(logat(0)), 32'h0100);
        chk("tbl done entry", 32'(done), 1);
        cyc(1);
        chk("tbl done one cycle", 32'(done), 0);
        chk("tbl done count", done_cnt - d0, 1);
        walk(sum, seq);
        chk("tbl walk sum", 32'(sum), 32'h15);

        // single value carrying in_last
        vals = '{8'h33};
        run_list(vals, 0, "single");

        // start during W_VAL is ignored, start in READY restarts
        wlog.delete();
        pulse_start();
        send(8'h11, 1'b0, ok);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        chk("wval start len", 32'(list_len), 1);
        chk("wval start writes", wlog.size(), 4);
        chk("wval start link", 32'(logat(3)), 32'h0102);
        chk("wval start ready", 32'(in_ready), 1);
        pulse_start();
        chk("restart len", 32'(list_len), 0);
        chk("restart init we", 32'(mem_we), 1);
        chk("restart init write", 32'({mem_addr, mem_wdata}), 32'h0100);
        cyc(2);

        // capacity: 127 nodes fill the space, the 128th is back-pressured
        wlog.delete();
        pulse_start();
        vals.delete();
        nok = 0;
        for (int i = 0; i < 127; i++) begin
            vals.push_back(8'($urandom));
            send(vals[i], 1'b0, ok);
            nok += int'(ok);
        end
        chk("full handshakes", nok, 127);
        cyc(3);
        chk("full flag", 32'(full), 1);
        chk("full in_ready", 32'(in_ready), 0);
        chk("full list_len", 32'(list_len), 127);
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rdy_seen += int'(in_ready);
            @(posedge clk);
            #1;
        end
        chk("full backpressure", rdy_seen, 0);
        chk("full still busy", 32'(busy), 1);
        in_last = 1'b1;
        cyc(1);
        in_valid = 1'b0; in_last = 1'b0;
        chk("full drop done", 32'(done), 1);
        chk("full drop idle", 32'(busy), 0);
        cyc(2);
        check_result("full", vals);

        // randomized lists against the reference model
        for (int r = 0; r < 8; r++) begin
            vals.delete();
            for (int i = 0; i < int'($urandom_range(12, 1)); i++)
                vals.push_back(($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom));
            run_list(vals, 3, $sformatf("rand%0d", r));
        end

        // asynchronous reset in W_NXT
        wlog.delete();
        pulse_start();
        send(8'h44, 1'b0, ok);
        cyc(1);
        #2 rst = 1'b1;
        #1;
        check_zero_outs("async rst");
        n0 = wlog.size();
        #2 rst = 1'b0;
        cyc(10);
        chk("post rst no writes", wlog.size(), n0);
        chk("post rst busy", 32'(busy), 0);
        chk("post rst in_ready", 32'(in_ready), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/list_builder.md
Name: list_builder

Overview:
- Writer-side counterpart of the linked-list summing datapath. Accepts a stream of values over a valid/ready handshake and builds a null-terminated singly linked list in the shared memory through a single write port.
- The existing walker can then traverse and sum the list.
- Memory layout:
  - Word 0 is reserved and never written.
  - Word 1 holds the head pointer.
  - A node at even address A holds the value at A and the next pointer at A+1.
  - Pointer value 0 means end of list.

Parameters:
- BITWIDTH, 8, data and address width; memory depth is 2^BITWIDTH words.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a new (empty) list; one-cycle pulse
- in_valid  input  1  in_data is valid
- in_data  input  BITWIDTH  node value to store
- in_last  input  1  marks the final value of the list; qualified by in_valid
- in_ready  output  1  block can accept a value this cycle
- mem_we  output  1  memory write enable
- mem_addr  output  BITWIDTH  memory write address
- mem_wdata  output  BITWIDTH  memory write data
- busy  output  1  high in any state other than IDLE or DONE
- done  output  1  one-cycle pulse when the list is complete
- full  output  1  node space exhausted
- list_len  output  BITWIDTH  number of nodes linked so far

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - All outputs are 0: mem_we, mem_addr, mem_wdata, in_ready, busy, done, full, list_len.
  - Internal registers reset: free_ptr=2, head=0, tail=0, last_flag=0.
- States: IDLE, INIT, READY, W_VAL, W_NXT, W_LINK, DONE.
- IDLE/DONE + start:
  - Go to INIT; reset free_ptr=2, head=0, tail=0, list_len=0, full=0.
  - INIT (1 cycle): mem_we=1, addr=1, wdata=0 (empty list). Then go to READY.
- READY:
  - in_ready = ~full.
  - Handshake (in_valid & in_ready): latch value=in_data, A=free_ptr, last_flag=in_last; go to W_VAL.
  - If full & in_valid & in_last: beat is dropped; go to DONE.
- W_VAL: mem_we=1, addr=A, wdata=value.
- W_NXT: mem_we=1, addr=A+1, wdata=0.
- W_LINK:
  - mem_we=1, wdata=A; addr=1 if head==0, else tail+1.
  - head=A if it was 0; tail=A; list_len+1; free_ptr=A+2.
  - full=1 if free_ptr wraps to 0.
  - Go to DONE if last_flag, else READY.
- DONE: done=1 for exactly one cycle (the entry cycle), then remain in DONE until start.
- Handshake and write-port timing:
  - in_ready is 0 in every state except READY, so throughput is 1 value per 4 cycles.
  - mem_we is 0 in IDLE, READY and DONE; mem_addr and mem_wdata hold their last value while mem_we=0.
- Start handling:
  - start is honoured only in IDLE, READY and DONE.
  - In READY, start wins over a simultaneous handshake.
  - start is ignored in INIT and in the W_* states, so a node is never half-linked.
- Capacity:
  - Nodes occupy 2,4,...,2^BITWIDTH-2, i.e. 2^(BITWIDTH-1)-1 nodes (127 at BITWIDTH=8).
  - Once full, in_ready=0; later values are back-pressured and never written.
- Arithmetic: all address arithmetic is modulo 2^BITWIDTH. in_data=0 is a legal value.
- Reset mid-operation: the list is abandoned immediately and no further writes occur. The list in memory may be inconsistent until the next start.

Optional Feature:
- LIST_PREPEND_EN defined (prepend mode):
  - W_NXT writes wdata=head.
  - W_LINK always writes addr=1, wdata=A; then head=A.
  - The list is in reverse arrival order; tail is unused.
- LIST_PREPEND_EN undefined: append mode as specified above.
- list_len, full, done and timing are identical in both modes.

Test Plan:
- Reset asserted mid-W_NXT -> every output is 0 immediately, without waiting for a clock edge. After release, no writes until start.
- start, values 5,7,9 (last on 9) -> writes (1,0), (2,5), (3,0), (1,2), (4,7), (5,0), (3,4), (6,9), (7,0), (5,6). Then done pulse, list_len=3. The walker reads sum=0x15.
- start then valid with in_last on the first value 0x33 -> writes (1,0), (2,0x33), (3,0), (1,2); done; list_len=1.
- Stream of 128 values at BITWIDTH=8 -> 127 nodes linked, full=1 and in_ready stays 0. The 128th value is never written; if it carries in_last -> DONE.
- start pulsed during W_VAL -> ignored: the node completes its three writes and list_len increments. start in the next READY cycle -> INIT write (1,0), list_len=0.
- With LIST_PREPEND_EN, values 5,7 -> writes (1,0), (2,5), (3,0), (1,2), (4,7), (5,2), (1,4). The walker sums to 0x0C.
